// File: rtl/b06_pkg.sv
// Shared constants and counter state encoding for the b06 qualifier/count stage.
package b06_pkg;

   localparam int                CNT_W         = 4;
   localparam int                SYNC_STAGES   = 2;
   localparam int                DEB_CYC       = 3;
   localparam logic [CNT_W-1:0]  DEFAULT_LIMIT = 4'd5;

   // HIT is the only state with bit 1 set, so CONT_EQL can come from one flop.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HIT  = 2'b10
   } cnt_state_e;

endpackage

// File: rtl/b06_sync_debounce.sv
// Synchroniser chain on the raw request followed by a mismatch-run debouncer.
module b06_sync_debounce #(
   parameter int SYNC_STAGES = b06_pkg::SYNC_STAGES,
   parameter int DEB_CYC     = b06_pkg::DEB_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic irq_in,
   output logic eql
);

   localparam int DW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
   logic                   eql_q, eql_d;
   logic                   irq_s;

   assign irq_s = sync_q[SYNC_STAGES-1];
   assign eql   = eql_q;

   // Next values: shift the request in, count consecutive disagreeing cycles.
   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], irq_in};
      eql_d     = eql_q;
      deb_cnt_d = '0;
      if (irq_s != eql_q) begin
         if (deb_cnt_q == DW'(DEB_CYC - 1)) begin
            eql_d     = irq_s;
            deb_cnt_d = '0;
         end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
         end
      end
   end

   // State flops, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= '0;
         deb_cnt_q <= '0;
         eql_q     <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         deb_cnt_q <= deb_cnt_d;
         eql_q     <= eql_d;
      end
   end

endmodule

// File: rtl/b06_eql_counter.sv
// Request qualifier plus enable-gated event counter feeding the b06 handler.
module b06_eql_counter #(
   parameter int               CNT_W         = b06_pkg::CNT_W,
   parameter int               SYNC_STAGES   = b06_pkg::SYNC_STAGES,
   parameter int               DEB_CYC       = b06_pkg::DEB_CYC,
   parameter logic [CNT_W-1:0] DEFAULT_LIMIT = b06_pkg::DEFAULT_LIMIT
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             IRQ_IN,
   input  logic             ENABLE_COUNT,
   input  logic             ACKOUT,
   input  logic             LIMIT_LOAD,
   input  logic [CNT_W-1:0] LIMIT_IN,
   output logic             EQL,
   output logic             CONT_EQL,
   output logic [CNT_W-1:0] COUNT,
   output logic             LIMIT_ERR
);

   import b06_pkg::cnt_state_e;
   import b06_pkg::IDLE;
   import b06_pkg::RUN;
   import b06_pkg::HIT;

   cnt_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic             limit_err_q, limit_err_d;
   logic [CNT_W-1:0] count_inc;

   b06_sync_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYC     (DEB_CYC)
   ) u_sync_debounce (
      .clk    (CLOCK),
      .rst    (RESET),
      .irq_in (IRQ_IN),
      .eql    (EQL)
   );

   // State register: FSM, count, limit and reject pulse, all async-cleared.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         count_q     <= '0;
         limit_q     <= DEFAULT_LIMIT;
         limit_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         limit_q     <= limit_d;
         limit_err_q <= limit_err_d;
      end
   end

   // Next-state logic: ACKOUT aborts, low enable pauses RUN but ends HIT.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      limit_d     = limit_q;
      limit_err_d = 1'b0;
      count_inc   = count_q + CNT_W'(1);
      case (state_q)
         IDLE: begin
            count_d = '0;
            if (ENABLE_COUNT && !ACKOUT) begin
               count_d = CNT_W'(1);
               // A limit of 0 is treated as 1: the first enabled cycle hits.
               state_d = (limit_q <= CNT_W'(1)) ? HIT : RUN;
            end
         end
         RUN: begin
            if (ACKOUT) begin
               state_d = IDLE;
               count_d = '0;
            end else if (ENABLE_COUNT) begin
               count_d = count_inc;
               if (count_inc == limit_q) begin
                  state_d = HIT;
               end
            end
         end
         HIT: begin
            if (ACKOUT || !ENABLE_COUNT) begin
               state_d = IDLE;
               count_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
      // The limit only changes while idle with no run about to start.
      if (LIMIT_LOAD) begin
         if ((state_q == IDLE) && !ENABLE_COUNT) begin
            limit_d = LIMIT_IN;
         end else begin
            limit_err_d = 1'b1;
         end
      end
   end

   // Outputs straight from flops; CONT_EQL is the HIT bit of the state.
   always_comb begin
      CONT_EQL  = state_q[1];
      COUNT     = count_q;
      LIMIT_ERR = limit_err_q;
   end

endmodule

// File: tb/tb_b06_eql_counter.sv
// Table-driven, scoreboarded bench for b06_eql_counter.
module tb_b06_eql_counter;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b1;
   logic       IRQ_IN = 1'b0;
   logic       ENABLE_COUNT = 1'b0;
   logic       ACKOUT = 1'b0;
   logic       LIMIT_LOAD = 1'b0;
   logic [3:0] LIMIT_IN = 4'd0;
   logic       EQL;
   logic       CONT_EQL;
   logic [3:0] COUNT;
   logic       LIMIT_ERR;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit         en;
      bit         ack;
      bit         ld;
      logic [3:0] lim;
      bit         irq;
      logic [3:0] exp_count;
      bit         exp_cont;
      bit         exp_err;
      bit         exp_eql;
   } vec_t;

   typedef struct {
      logic [3:0] count;
      bit         cont;
      bit         err;
      bit         eql;
   } exp_t;

   exp_t sb_q[$];
   vec_t tbl[$];

   b06_eql_counter dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .IRQ_IN       (IRQ_IN),
      .ENABLE_COUNT (ENABLE_COUNT),
      .ACKOUT       (ACKOUT),
      .LIMIT_LOAD   (LIMIT_LOAD),
      .LIMIT_IN     (LIMIT_IN),
      .EQL          (EQL),
      .CONT_EQL     (CONT_EQL),
      .COUNT        (COUNT),
      .LIMIT_ERR    (LIMIT_ERR)
   );

   always #5 CLOCK = ~CLOCK;

   function automatic vec_t mk(bit en, bit ack, bit ld, logic [3:0] lim, bit irq,
                               logic [3:0] cnt, bit cont, bit err, bit eql);
      vec_t v;
      v.en = en; v.ack = ack; v.ld = ld; v.lim = lim; v.irq = irq;
      v.exp_count = cnt; v.exp_cont = cont; v.exp_err = err; v.exp_eql = eql;
      return v;
   endfunction

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // One clock per vector: push expectation, drive, clock, pop and compare.
   task automatic apply(input vec_t v, input string nm);
      exp_t e;
      e.count = v.exp_count; e.cont = v.exp_cont; e.err = v.exp_err; e.eql = v.exp_eql;
      sb_q.push_back(e);
      @(negedge CLOCK);
      ENABLE_COUNT = v.en;
      ACKOUT       = v.ack;
      LIMIT_LOAD   = v.ld;
      LIMIT_IN     = v.lim;
      IRQ_IN       = v.irq;
      @(posedge CLOCK);
      #1;
      if (sb_q.size() == 0) begin
         check({nm, "_sb_empty"}, 8'd1, 8'd0);
      end else begin
         e = sb_q.pop_front();
         $display("%s en=%0b ack=%0b ld=%0b lim=%0d irq=%0b -> count=%0d cont=%0b err=%0b eql=%0b",
                  nm, v.en, v.ack, v.ld, v.lim, v.irq, COUNT, CONT_EQL, LIMIT_ERR, EQL);
         check({nm, "_count"}, {4'd0, COUNT}, {4'd0, e.count});
         check({nm, "_cont"},  {7'd0, CONT_EQL},  {7'd0, e.cont});
         check({nm, "_err"},   {7'd0, LIMIT_ERR}, {7'd0, e.err});
         check({nm, "_eql"},   {7'd0, EQL},       {7'd0, e.eql});
      end
   endtask

   task automatic release_reset();
      @(negedge CLOCK);
      ENABLE_COUNT = 0; ACKOUT = 0; LIMIT_LOAD = 0; LIMIT_IN = 0; IRQ_IN = 0;
      RESET = 0;
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_count"}, {4'd0, COUNT}, 8'd0);
      check({nm, "_cont"},  {7'd0, CONT_EQL},  8'd0);
      check({nm, "_err"},   {7'd0, LIMIT_ERR}, 8'd0);
      check({nm, "_eql"},   {7'd0, EQL},       8'd0);
   endtask

   initial begin
      //            en ack ld lim irq  cnt cont err eql
      // count to default limit 5, hold, drop enable
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 2, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 3, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 4, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      // pause at 2 for three cycles, resume to 5, ack from HIT
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 2, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 3, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 4, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      // abort at 3 with ack over enable, ack in idle blocks start
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 2, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 3, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      // load during RUN rejected, limit stays 5
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 1, 2, 0, 2, 0, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 3, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 4, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      // load 0 in IDLE: hits on first enabled edge
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      // load with enable in IDLE: rejected, run uses old limit 0
      tbl.push_back(mk(1, 0, 1, 3, 0, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      // load 3 in IDLE, count to 3
      tbl.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 2, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // reset state while RESET is held
      #12;
      check_reset_outputs("reset_init");
      release_reset();

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("tbl%0d", i));
      end

      // glitch: two high cycles never flip EQL (limit is 3, idle)
      for (int i = 0; i < 8; i++) begin
         apply(mk(0, 0, 0, 0, (i < 2), 0, 0, 0, 0), $sformatf("glitch%0d", i));
      end

      // shortest passing pulse: three high cycles, EQL high on edges 5..7
      for (int i = 0; i < 10; i++) begin
         apply(mk(0, 0, 0, 0, (i < 3), 0, 0, 0, (i >= 4 && i <= 6)),
               $sformatf("pulse3_%0d", i));
      end

      // clean rise: EQL on the fifth edge after IRQ_IN goes high
      for (int i = 0; i < 6; i++) begin
         apply(mk(0, 0, 0, 0, 1, 0, 0, 0, (i >= 4)), $sformatf("rise%0d", i));
      end

      // mid-run reset with EQL high and LIMIT_ERR pulsing
      apply(mk(1, 0, 0, 0, 1, 1, 0, 0, 1), "prerst0");
      apply(mk(1, 0, 1, 2, 1, 2, 0, 1, 1), "prerst1");
      @(negedge CLOCK);
      #2;
      RESET = 1'b1;
      #1;
      check_reset_outputs("reset_async");
      release_reset();

      // limit back to 5 after reset; EQL re-qualifies independently of counting
      for (int i = 0; i < 5; i++) begin
         apply(mk(1, 0, 0, 0, 1, 4'(i + 1), (i == 4), 0, (i >= 4)),
               $sformatf("postrst%0d", i));
      end
      apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 1), "postrst_drop");

      // clean fall: EQL drops on the fifth edge after IRQ_IN goes low
      for (int i = 0; i < 6; i++) begin
         apply(mk(0, 0, 0, 0, 0, 0, 0, 0, (i < 4)), $sformatf("fall%0d", i));
      end

      if (sb_q.size() != 0) begin
         check("sb_leftover", 8'(sb_q.size()), 8'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
